// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller
//   Multi-floor elevator controller. Floor requests are latched into a
//   pending bitmap and served in SCAN order: the car keeps sweeping in its
//   current direction while requests remain ahead, then reverses. Travel
//   between adjacent floors takes TRAVEL_CYCLES clocks and each stop holds
//   the door open for DOOR_CYCLES clocks.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   req_valid      request strobe, sampled every rising edge
//   req_floor      requested floor, qualified by req_valid
//   estop          emergency stop: freezes state, timer and floor while high
//   current_floor  floor the car is at / last passed
//   dir_up         sweep direction (1 = up)
//   moving         car travelling and not stopped by estop
//   door_open      door held open at a stop
//   arrived        one-cycle pulse in the first door cycle of a stop
//   pending        registered request bitmap, bit i = floor i requested
module elevator_scan_controller #(
  parameter int unsigned NUM_FLOORS    = 10,
  parameter int unsigned FLOOR_W       = 4,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  estop,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  localparam logic [CNT_W-1:0]   TRAVEL_LD = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0]   DOOR_LD   = CNT_W'(DOOR_CYCLES);
  localparam logic [CNT_W-1:0]   ONE       = CNT_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state_q,   state_d;
  logic [CNT_W-1:0]        timer_q,   timer_d;
  logic [FLOOR_W-1:0]      floor_q,   floor_d;
  logic                    dir_up_q,  dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    arrived_q, arrived_d;

  logic                    req_ok;
  logic                    req_here;
  logic [FLOOR_W-1:0]      next_floor;
  logic [NUM_FLOORS-1:0]   req_bit;
  logic [NUM_FLOORS-1:0]   here_mask;
  logic [NUM_FLOORS-1:0]   above_mask;
  logic [NUM_FLOORS-1:0]   below_mask;
  logic [NUM_FLOORS-1:0]   next_bit;
  logic [NUM_FLOORS-1:0]   ahead_mask;

  // Floor-relative masks: relative to the current floor for IDLE decisions,
  // relative to the floor being reached for the arrival-edge decision.
  always_comb begin
    req_ok     = req_valid && (req_floor <= TOP_FLOOR);
    req_here   = req_ok && (req_floor == floor_q);
    next_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    req_bit    = '0;
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    next_bit   = '0;
    ahead_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      req_bit[i]    = req_ok && (req_floor == FLOOR_W'(i));
      here_mask[i]  = (FLOOR_W'(i) == floor_q);
      above_mask[i] = (FLOOR_W'(i) > floor_q);
      below_mask[i] = (FLOOR_W'(i) < floor_q);
      next_bit[i]   = (FLOOR_W'(i) == next_floor);
      ahead_mask[i] = (state_q == MOVE_UP) ? (FLOOR_W'(i) > next_floor)
                                           : (FLOOR_W'(i) < next_floor);
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    pending_d = pending_q;
    arrived_d = 1'b0;

    if (estop) begin
      // Everything frozen, but no request may be dropped.
      pending_d = pending_q | req_bit;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_here) begin
            state_d   = DOOR;
            timer_d   = DOOR_LD;
            arrived_d = 1'b1;
          end else begin
            pending_d = pending_q | req_bit;
            // A bit for the current floor can only be left over from an
            // estop window; serve it on the spot.
            if (|(pending_q & here_mask)) begin
              pending_d = pending_d & ~here_mask;
              state_d   = DOOR;
              timer_d   = DOOR_LD;
              arrived_d = 1'b1;
            end else if (|(pending_q & above_mask) &&
                         (dir_up_q || !(|(pending_q & below_mask)))) begin
              state_d  = MOVE_UP;
              dir_up_d = 1'b1;
              timer_d  = TRAVEL_LD;
            end else if (|(pending_q & below_mask)) begin
              state_d  = MOVE_DOWN;
              dir_up_d = 1'b0;
              timer_d  = TRAVEL_LD;
            end
          end
        end

        MOVE_UP, MOVE_DOWN: begin
          pending_d = pending_q | req_bit;
          if (timer_q > ONE) begin
            timer_d = timer_q - ONE;
          end else begin
            floor_d = next_floor;
            // pending_d already folds in a request arriving on this edge,
            // so a simultaneous request for the new floor is absorbed.
            if (|(pending_d & next_bit)) begin
              pending_d = pending_d & ~next_bit;
              state_d   = DOOR;
              timer_d   = DOOR_LD;
              arrived_d = 1'b1;
            end else if (|(pending_d & ahead_mask)) begin
              timer_d = TRAVEL_LD;
            end else begin
              state_d = IDLE;
            end
          end
        end

        DOOR: begin
          if (req_here) begin
            timer_d = DOOR_LD;
          end else begin
            pending_d = pending_q | req_bit;
            if (timer_q > ONE) begin
              timer_d = timer_q - ONE;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      arrived_q <= arrived_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_up_q;
  assign pending       = pending_q;
  assign arrived       = arrived_q;
  assign door_open     = (state_q == DOOR);
  assign moving        = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && !estop;

endmodule

// File: tb/tb_elevator_scan_controller.sv
module tb_elevator_scan_controller;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          estop = 1'b0;
  logic [FW-1:0] current_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic          arrived;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  elevator_scan_controller #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .estop        (estop),
    .current_floor(current_floor),
    .dir_up       (dir_up),
    .moving       (moving),
    .door_open    (door_open),
    .arrived      (arrived),
    .pending      (pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: car position, sweep direction, request set and a
  // countdown of cycles left in the current activity.
  localparam int MD_IDLE = 0;
  localparam int MD_UP   = 1;
  localparam int MD_DN   = 2;
  localparam int MD_DOOR = 3;

  int          m_floor;
  bit          m_up;
  bit [NF-1:0] m_pend;
  int          m_mode;
  int          m_left;
  bit          m_arr;
  bit          m_es;

  function automatic bit any_set(input bit [NF-1:0] p, input int lo, input int hi);
    for (int f = 0; f < NF; f++)
      if (f >= lo && f <= hi && p[f]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_pend = '0; m_mode = MD_IDLE; m_left = 0; m_arr = 1'b0; m_es = 1'b0;
  endtask

  task automatic model_stop_here();
    m_pend[m_floor] = 1'b0;
    m_mode = MD_DOOR;
    m_left = DC;
    m_arr  = 1'b1;
  endtask

  task automatic model_step(input bit rv, input int rf, input bit es);
    bit take;
    bit ab;
    bit be;
    take  = rv && (rf < NF);
    m_arr = 1'b0;
    if (es) begin
      if (take) m_pend[rf] = 1'b1;
      return;
    end
    case (m_mode)
      MD_IDLE: begin
        if (take && rf == m_floor) begin
          model_stop_here();
        end else begin
          ab = any_set(m_pend, m_floor + 1, NF - 1);
          be = any_set(m_pend, 0, m_floor - 1);
          if (m_pend[m_floor]) model_stop_here();
          else if (ab && (m_up || !be)) begin m_mode = MD_UP; m_up = 1'b1; m_left = TC; end
          else if (be) begin m_mode = MD_DN; m_up = 1'b0; m_left = TC; end
          if (take) m_pend[rf] = 1'b1;
        end
      end
      MD_UP, MD_DN: begin
        if (take) m_pend[rf] = 1'b1;
        if (m_left > 1) m_left--;
        else begin
          m_floor += (m_mode == MD_UP) ? 1 : -1;
          if (m_pend[m_floor]) model_stop_here();
          else if ((m_mode == MD_UP) ? any_set(m_pend, m_floor + 1, NF - 1)
                                     : any_set(m_pend, 0, m_floor - 1)) m_left = TC;
          else m_mode = MD_IDLE;
        end
      end
      default: begin
        if (take && rf == m_floor) m_left = DC;
        else begin
          if (take) m_pend[rf] = 1'b1;
          if (m_left > 1) m_left--;
          else m_mode = MD_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("floor",   32'(current_floor), 32'(m_floor));
    check("dir_up",  32'(dir_up),        32'(m_up));
    check("moving",  32'(moving),        32'((m_mode == MD_UP || m_mode == MD_DN) && !m_es));
    check("door",    32'(door_open),     32'(m_mode == MD_DOOR));
    check("arrived", 32'(arrived),       32'(m_arr));
    check("pending", 32'(pending),       32'(m_pend));
    check("floor_bound", 32'(int'(current_floor) <= NF - 1), 32'(1));
  endtask

  // One clock: drive inputs for this cycle, advance DUT and model together,
  // compare just after the edge, return on the next falling edge.
  task automatic cycle(input bit rv, input int rf, input bit es);
    logic [31:0] rf_v;
    rf_v      = rf;
    req_valid = rv;
    req_floor = rf_v[FW-1:0];
    estop     = es;
    m_es      = es;
    @(posedge clk);
    model_step(rv, rf, es);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic wait_settled(input string tag, input int budget);
    int k;
    k = 0;
    while (!(m_mode == MD_IDLE && m_pend == '0) && k < budget) begin
      cycle(1'b0, 0, 1'b0);
      k++;
    end
    check(tag, 32'(k < budget), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stops[$];
    int dirs[$];
    int k;
    int es_run;
    bit rv;
    bit es;
    int rf;

    // Reset state
    model_reset();
    #23;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(2);

    // Single request to floor 2 with exact timing
    cycle(1'b1, 2, 1'b0);                                  // now cycle 1
    check("s2_pend_c1", 32'(pending), 32'h004);
    check("s2_idle_c1", 32'(moving), 32'(0));
    cycle(1'b0, 0, 1'b0);                                  // cycle 2
    check("s2_moving_c2", 32'(moving), 32'(1));
    idle_cycles(4);                                        // cycle 6
    check("s2_floor1_c6", 32'(current_floor), 32'(1));
    idle_cycles(3);                                        // cycle 9
    check("s2_floor1_c9", 32'(current_floor), 32'(1));
    cycle(1'b0, 0, 1'b0);                                  // cycle 10
    check("s2_floor2_c10", 32'(current_floor), 32'(2));
    check("s2_door_c10", 32'(door_open), 32'(1));
    check("s2_arrived_c10", 32'(arrived), 32'(1));
    check("s2_pend_c10", 32'(pending), 32'(0));
    idle_cycles(2);                                        // cycle 12
    check("s2_door_c12", 32'(door_open), 32'(1));
    check("s2_arrived_c12", 32'(arrived), 32'(0));
    cycle(1'b0, 0, 1'b0);                                  // cycle 13
    check("s2_closed_c13", 32'(door_open), 32'(0));

    // Emergency stop for 5 cycles mid-travel, floor 2 -> 4
    cycle(1'b1, 4, 1'b0);                                  // cycle 1
    for (int j = 1; j <= 14; j++) begin
      cycle(1'b0, 0, (j >= 3 && j <= 7));                  // now cycle j+1
      if (j >= 3 && j <= 7) begin
        check("s5_frozen_moving", 32'(moving), 32'(0));
        check("s5_frozen_floor", 32'(current_floor), 32'(2));
      end
      if (j == 9)  check("s5_floor2_c10", 32'(current_floor), 32'(2));
      if (j == 10) check("s5_floor3_c11", 32'(current_floor), 32'(3));
      if (j == 13) check("s5_nodoor_c14", 32'(door_open), 32'(0));
    end
    check("s5_floor4_c15", 32'(current_floor), 32'(4));
    check("s5_door_c15", 32'(door_open), 32'(1));
    check("s5_arrived_c15", 32'(arrived), 32'(1));
    idle_cycles(3);

    // Request for the floor the idle car is on, then re-request during door
    cycle(1'b1, 4, 1'b0);                                  // cycle 1
    check("s4_door_c1", 32'(door_open), 32'(1));
    check("s4_pend_c1", 32'(pending), 32'(0));
    cycle(1'b0, 0, 1'b0);                                  // cycle 2
    cycle(1'b1, 4, 1'b0);                                  // cycle 3
    idle_cycles(2);                                        // cycle 5
    check("s4_door_ext_c5", 32'(door_open), 32'(1));
    check("s4_pend_c5", 32'(pending), 32'(0));
    cycle(1'b0, 0, 1'b0);                                  // cycle 6
    check("s4_closed_c6", 32'(door_open), 32'(0));

    // Out-of-range requests are ignored
    cycle(1'b1, 10, 1'b0);
    check("s6_oor10", 32'(pending), 32'(0));
    cycle(1'b1, 15, 1'b0);
    check("s6_oor15", 32'(pending), 32'(0));

    // Sweep: heading to 6, requests 1 and 5 injected on the way up
    cycle(1'b1, 6, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 5, 1'b0);
    k = 0;
    while (!(stops.size() == 3 && !door_open && !moving) && k < 300) begin
      cycle(1'b0, 0, 1'b0);
      if (arrived) begin
        stops.push_back(int'(current_floor));
        dirs.push_back(int'(dir_up));
      end
      k++;
    end
    check("s3_nstops", 32'(stops.size()), 32'(3));
    if (stops.size() == 3) begin
      check("s3_stop0", 32'(stops[0]), 32'(5));
      check("s3_dir0",  32'(dirs[0]),  32'(1));
      check("s3_stop1", 32'(stops[1]), 32'(6));
      check("s3_dir1",  32'(dirs[1]),  32'(1));
      check("s3_stop2", 32'(stops[2]), 32'(1));
      check("s3_dir2",  32'(dirs[2]),  32'(0));
    end
    check("s3_pend_end", 32'(pending), 32'(0));

    // Randomized traffic with occasional emergency stops
    es_run = 0;
    for (int n = 0; n < 2000; n++) begin
      rv = ($urandom_range(0, 99) < 15);
      rf = int'($urandom_range(0, 11));
      if (es_run > 0) begin
        es = 1'b1;
        es_run--;
      end else if ($urandom_range(0, 99) < 2) begin
        es = 1'b1;
        es_run = int'($urandom_range(0, 5));
      end else begin
        es = 1'b0;
      end
      cycle(rv, rf, es);
    end
    wait_settled("rand_settle", 400);

    // Asynchronous reset while travelling down
    cycle(1'b1, 7, 1'b0);
    wait_settled("s6_reach7", 200);
    cycle(1'b1, 2, 1'b0);
    k = 0;
    while (m_mode != MD_DN && k < 20) begin
      cycle(1'b0, 0, 1'b0);
      k++;
    end
    check("s6_moving_down", 32'(m_mode == MD_DN && moving && !dir_up), 32'(1));
    idle_cycles(5);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("s6_rst_floor",   32'(current_floor), 32'(0));
    check("s6_rst_pending", 32'(pending),       32'(0));
    check("s6_rst_moving",  32'(moving),        32'(0));
    check("s6_rst_door",    32'(door_open),     32'(0));
    check("s6_rst_dir",     32'(dir_up),        32'(1));
    check("s6_rst_arrived", 32'(arrived),       32'(0));
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
